// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
//  Module   : riscv_ctrl_pkg
//  Purpose  : Encodings shared by the RV32I multicycle controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_dec.sv
// ============================================================================
//  Module   : ALU_Dec
//  Purpose  : ALU operation decode from ALUOp and instruction function fields.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ALU_Dec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = 3'b000;
    case (ALUOp)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      default: begin
        case (funct3)
          // Subtract only for R-type; addi with imm[10]=1 must stay an add.
          3'b000:  ALUControl = (opb5 & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b100:  ALUControl = 3'b100;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Moore controller sequencing the shared RV32I multicycle datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic       w_mem_req, w_irwrite, w_pcupdate, w_branch, w_regwrite, w_memwrite;
  logic [1:0] w_aluop;
  logic       w_retire;
  logic       w_unused_funct7;

  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
      instr_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_op_d = illegal_op_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  assign w_retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                    ((state_q == S_MEMWRITE) && mem_ready);

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (w_retire) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_comb begin
    w_mem_req  = 1'b0;
    w_irwrite  = 1'b0;
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    w_aluop    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_irwrite  = mem_ready;
        w_pcupdate = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req  = 1'b1;
        AdrSrc     = 1'b1;
        w_memwrite = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        w_aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        w_aluop   = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        w_branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALUOUT;
        w_pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by the raw reset so nothing fires while it is held.
  assign mem_req  = w_mem_req  & rst;
  assign IRWrite  = w_irwrite  & rst;
  assign PCWrite  = (w_pcupdate | (w_branch & Zero)) & rst;
  assign RegWrite = w_regwrite & rst;
  assign MemWrite = w_memwrite & rst;

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  ALU_Dec u_alu_dec (
    .ALUOp      (w_aluop),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .opb5       (Op[5]),
    .ALUControl (ALUControl)
  );

  assign illegal_op = illegal_op_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Directed self-checking bench for the multicycle controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        illegal_op;
  logic [31:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal_op (illegal_op),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe vector {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite}.
  function automatic logic [5:0] strobes();
    return {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite};
  endfunction

  initial begin
    rst = 1'b0; Op = 7'b0; funct3 = 3'b0; funct7 = 7'b0; Zero = 1'b0; mem_ready = 1'b1;
    #23;
    chk("rst_strobes", 32'(strobes()), 32'h0);
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_srcb", 32'(ALUSrcB), 32'h2);
    chk("rst_ressrc", 32'(ResultSrc), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;

    // lw, 5 cycles
    Op = 7'b0000011; mem_ready = 1'b1; #1;
    chk("lw_fetch_strobes", 32'(strobes()), 32'b101100);
    cyc();
    chk("lw_decode_srca", 32'(ALUSrcA), 32'h1);
    chk("lw_decode_strobes", 32'(strobes()), 32'h0);
    cyc();
    chk("lw_memadr_srcab", 32'({ALUSrcA, ALUSrcB}), 32'b1001);
    chk("lw_memadr_strobes", 32'(strobes()), 32'h0);
    cyc();
    chk("lw_memread_strobes", 32'(strobes()), 32'b110000);
    cyc();
    chk("lw_memwb_strobes", 32'(strobes()), 32'b000010);
    chk("lw_memwb_ressrc", 32'(ResultSrc), 32'h1);
    chk("lw_memwb_cnt", instr_cnt, 32'd0);
    cyc();
    chk("lw_done_cnt", instr_cnt, 32'd1);
    chk("lw_back_fetch", 32'(mem_req), 32'd1);

    // sw with three wait cycles in MEMWRITE
    Op = 7'b0100011; #1;
    cyc();
    chk("sw_immsrc", 32'(ImmSrc), 32'h1);
    cyc();
    cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_wait_strobes", 32'(strobes()), 32'b110000);
      cyc();
    end
    chk("sw_wait_cnt", instr_cnt, 32'd1);
    mem_ready = 1'b1; #1;
    chk("sw_write_strobes", 32'(strobes()), 32'b110001);
    cyc();
    chk("sw_done_cnt", instr_cnt, 32'd2);
    mem_ready = 1'b0; #1;
    chk("fetch_wait_strobes", 32'(strobes()), 32'b100000);
    cyc();
    chk("fetch_hold_strobes", 32'(strobes()), 32'b100000);
    mem_ready = 1'b1;

    // beq taken then not taken
    Op = 7'b1100011; Zero = 1'b1; #1;
    cyc();
    chk("beq_immsrc", 32'(ImmSrc), 32'h2);
    cyc();
    chk("beq_t_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_aluctl", 32'(ALUControl), 32'h1);
    chk("beq_srcab", 32'({ALUSrcA, ALUSrcB}), 32'b1000);
    cyc();
    chk("beq_t_cnt", instr_cnt, 32'd3);
    Zero = 1'b0; #1;
    cyc();
    cyc();
    chk("beq_nt_pcwrite", 32'(PCWrite), 32'd0);
    cyc();
    chk("beq_nt_cnt", instr_cnt, 32'd4);

    // add / sub R-type
    Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; #1;
    cyc();
    cyc();
    chk("add_aluctl", 32'(ALUControl), 32'h0);
    chk("add_srcab", 32'({ALUSrcA, ALUSrcB}), 32'b1000);
    cyc();
    chk("add_aluwb_strobes", 32'(strobes()), 32'b000010);
    cyc();
    chk("add_cnt", instr_cnt, 32'd5);
    funct7 = 7'b0100000; #1;
    cyc();
    cyc();
    chk("sub_aluctl", 32'(ALUControl), 32'h1);
    cyc();
    cyc();
    chk("sub_cnt", instr_cnt, 32'd6);

    // jal
    Op = 7'b1101111; funct7 = 7'b0; #1;
    cyc();
    chk("jal_immsrc", 32'(ImmSrc), 32'h3);
    cyc();
    chk("jal_strobes", 32'(strobes()), 32'b000100);
    chk("jal_srcab", 32'({ALUSrcA, ALUSrcB}), 32'b0110);
    cyc();
    chk("jal_aluwb_strobes", 32'(strobes()), 32'b000010);
    cyc();
    chk("jal_cnt", instr_cnt, 32'd7);

    // illegal opcode
    Op = 7'b1111111; #1;
    cyc();
    chk("ill_decode_flag", 32'(illegal_op), 32'd0);
    cyc();
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_back_fetch", 32'(strobes()), 32'b101100);
    chk("ill_cnt", instr_cnt, 32'd7);

    // addi after illegal: flag stays, counter resumes
    Op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000; #1;
    cyc();
    cyc();
    chk("addi_aluctl", 32'(ALUControl), 32'h0);
    chk("addi_srcb", 32'(ALUSrcB), 32'h1);
    cyc();
    cyc();
    chk("addi_cnt", instr_cnt, 32'd8);
    chk("ill_sticky", 32'(illegal_op), 32'd1);

    // reset in the middle of MEMWRITE
    Op = 7'b0100011; mem_ready = 1'b1; #1;
    cyc();
    cyc();
    cyc();
    chk("rstmid_memwrite", 32'(MemWrite), 32'd1);
    rst = 1'b0; #1;
    chk("rstmid_memwrite_off", 32'(MemWrite), 32'd0);
    chk("rstmid_cnt", instr_cnt, 32'd0);
    chk("rstmid_illegal", 32'(illegal_op), 32'd0);
    cyc();
    rst = 1'b1; mem_ready = 1'b0; #1;
    chk("rstrel_fetch", 32'(strobes()), 32'b100000);
    chk("rstrel_srcb", 32'(ALUSrcB), 32'h2);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
